write_back_buffer: RTL
======================

Name: write_back_buffer

Overview:
- Multi-entry write-back buffer between the cache controller and main memory.
- The controller loads evicted dirty lines word-by-word into the buffer.
- A drain state machine streams each line to memory one word at a time, under a per-word ack handshake with timeout and retry.
- Provides an address-match lookup so the controller can detect reads that hit a line still pending write-back.

Parameters:
NUM_ENTRIES, 4, number of buffered cache lines (power of two, >=2)
DATA_WIDTH, 32, bits per word
BLOCK_SIZE, 32, bytes per cache line; WORDS = BLOCK_SIZE*8/DATA_WIDTH (8 at defaults)
ADDRESS_WIDTH, 32, byte-address width; OFFSET = log2(BLOCK_SIZE)
COUNTER_WIDTH, 8, width of ack-timeout counter
ACK_TIMEOUT, 200, cycles in WAIT_ACK before retry; must be < 2**COUNTER_WIDTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
request  in  1  controller word valid (fill side)
dataIn  in  DATA_WIDTH  fill word
r_address  in  ADDRESS_WIDTH  line address, sampled on first word of a line
full  out  1  no free entry; a new line cannot start
occupancy  out  log2(NUM_ENTRIES)+1  committed lines held
readyToSend  out  1  dataOut/w_address/wordIndex valid for memory
waitingForAck  out  1  word sent, awaiting ack
dataOut  out  DATA_WIDTH  word to memory
w_address  out  ADDRESS_WIDTH  line address of word being sent, low OFFSET bits zero
wordIndex  out  log2(WORDS)  word position within line
ack  in  1  memory acknowledgement
lookupAddress  in  ADDRESS_WIDTH  snoop address
lookupHit  out  1  combinational: a committed entry matches lookupAddress[ADDRESS_WIDTH-1:OFFSET]
timeoutError  out  1  one-cycle pulse on each ack timeout

Behaviour:
- Reset values: all outputs 0; wrPtr=rdPtr=fillCnt=sendCnt=timer=0; all entries invalid; FSM=IDLE; any partial fill discarded.
- Fill:
  - request sampled each edge.
  - fillCnt==0 and full=1: word ignored.
  - Otherwise the word is written to entry[wrPtr].word[fillCnt]; when fillCnt==0, r_address[ADDRESS_WIDTH-1:OFFSET] is also captured.
  - On fillCnt==WORDS-1: the entry is marked valid (commit), wrPtr wraps modulo NUM_ENTRIES, occupancy+1, fillCnt returns to 0.
  - Once started, a line always completes; full never blocks it.
- full = (occupancy==NUM_ENTRIES). An in-progress line does not count until committed.
- Drain FSM, states IDLE, SEND, WAIT_ACK:
  - IDLE: occupancy>0 -> SEND.
  - SEND: readyToSend=1 for exactly one cycle. dataOut=entry[rdPtr].word[sendCnt], wordIndex=sendCnt, w_address = stored tag concatenated with OFFSET zeros. -> WAIT_ACK, timer=0.
  - WAIT_ACK: waitingForAck=1. dataOut, w_address and wordIndex are held stable.
    - ack=1 with sendCnt<WORDS-1: sendCnt+1, -> SEND.
    - ack=1 with sendCnt==WORDS-1: entry invalidated (pop), rdPtr wraps, occupancy-1, sendCnt=0, -> IDLE.
    - No ack and timer==ACK_TIMEOUT-1: timeoutError=1 for one cycle, -> SEND, same word resent.
    - Otherwise timer+1.
  - ack outside WAIT_ACK is ignored.
- Latency: the last fill word sampled at edge N commits the line. readyToSend is high in the cycle after edge N+1 when the FSM was IDLE. Back-to-back lines pass through IDLE for one cycle.
- Simultaneous commit and pop in one cycle: occupancy unchanged; both pointers advance.
- lookupHit covers committed entries only, including the line currently draining until its pop; it excludes the partially filled entry.
- Reset mid-drain or mid-fill: the line is lost; outputs return to reset values the next cycle.

Test Plan:
- Single line, defaults: 8 request cycles, dataIn=0x10..0x17, r_address=0x0000_1234 -> occupancy=1. readyToSend two cycles later with w_address=0x0000_1220, wordIndex 0..7, dataOut 0x10..0x17 in order, each word acked after 3 cycles. occupancy returns to 0.
- Fill 4 lines with memory not acking -> full=1 after the 4th commit. A 5th line's first word is ignored, occupancy stays 4. Ack resumes -> full drops after the first pop completes.
- Ack withheld 200 cycles in WAIT_ACK -> timeoutError one-cycle pulse, readyToSend reasserted with the same dataOut and wordIndex. Ack on retry -> advances to the next word.
- Commit of line 2 in the same cycle as the last-word ack of line 1 -> occupancy stays 1; line 2 drains next with the correct address.
- lookupAddress=0x0000_123C while line 0x1220 is buffered -> lookupHit=1. After pop -> 0. lookupAddress=0x0000_1240 -> 0 throughout.
- reset asserted in WAIT_ACK of word 3 with 2 lines buffered -> next cycle occupancy=0, readyToSend=waitingForAck=0, lookupHit=0. New fill accepted at entry 0.

Source files
------------

// File: rtl/write_back_buffer.sv
// Write-back buffer: the cache controller fills evicted lines one word at a time, and a drain FSM
// streams each committed line to memory with a per-word ack handshake, timeout and resend.
module write_back_buffer #(
    parameter int unsigned NUM_ENTRIES   = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BLOCK_SIZE    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned ACK_TIMEOUT   = 200
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          request,
    input  logic [DATA_WIDTH-1:0]                         dataIn,
    input  logic [ADDRESS_WIDTH-1:0]                      r_address,
    output logic                                          full,
    output logic [$clog2(NUM_ENTRIES):0]                  occupancy,
    output logic                                          readyToSend,
    output logic                                          waitingForAck,
    output logic [DATA_WIDTH-1:0]                         dataOut,
    output logic [ADDRESS_WIDTH-1:0]                      w_address,
    output logic [$clog2(BLOCK_SIZE*8/DATA_WIDTH)-1:0]    wordIndex,
    input  logic                                          ack,
    input  logic [ADDRESS_WIDTH-1:0]                      lookupAddress,
    output logic                                          lookupHit,
    output logic                                          timeoutError
);

    localparam int unsigned WORDS  = BLOCK_SIZE * 8 / DATA_WIDTH;
    localparam int unsigned OFFSET = $clog2(BLOCK_SIZE);
    localparam int unsigned PTR_W  = $clog2(NUM_ENTRIES);
    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned TAG_W  = ADDRESS_WIDTH - OFFSET;
    localparam int unsigned OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitAck} state_t;

    state_t                   r_state, w_state_next;
    logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
    logic [IDX_W-1:0]         r_fill_cnt, r_send_cnt, w_send_cnt_next;
    logic [COUNTER_WIDTH-1:0] r_timer, w_timer_next;
    logic [OCC_W-1:0]         r_occ;
    logic [NUM_ENTRIES-1:0]   r_valid;
    logic                     r_timeout;
    logic [TAG_W-1:0]         r_tag  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]    r_data [NUM_ENTRIES][WORDS];

    logic w_accept, w_commit, w_pop, w_timeout, w_draining;

    assign full = (r_occ == OCC_W'(NUM_ENTRIES));

    // A line may only start while a free entry exists; once started it always completes.
    assign w_accept = request && !((r_fill_cnt == '0) && full);
    assign w_commit = w_accept && (r_fill_cnt == IDX_W'(WORDS - 1));

    always_comb begin
        w_state_next    = r_state;
        w_send_cnt_next = r_send_cnt;
        w_timer_next    = r_timer;
        w_pop           = 1'b0;
        w_timeout       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_occ != '0) w_state_next = StSend;
            end
            StSend: begin
                w_state_next = StWaitAck;
                w_timer_next = '0;
            end
            StWaitAck: begin
                if (ack) begin
                    if (r_send_cnt == IDX_W'(WORDS - 1)) begin
                        w_pop           = 1'b1;
                        w_send_cnt_next = '0;
                        w_state_next    = StIdle;
                    end else begin
                        w_send_cnt_next = r_send_cnt + 1'b1;
                        w_state_next    = StSend;
                    end
                end else if (r_timer == COUNTER_WIDTH'(ACK_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StSend;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_cnt <= '0;
            r_send_cnt <= '0;
            r_timer    <= '0;
            r_occ      <= '0;
            r_valid    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_send_cnt <= w_send_cnt_next;
            r_timer    <= w_timer_next;
            r_timeout  <= w_timeout;
            if (w_accept) r_fill_cnt <= w_commit ? '0 : r_fill_cnt + 1'b1;
            if (w_commit) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_commit, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by r_valid or the drain state.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_data[r_wr_ptr][r_fill_cnt] <= dataIn;
            if (r_fill_cnt == '0) r_tag[r_wr_ptr] <= r_address[ADDRESS_WIDTH-1:OFFSET];
        end
    end

    assign w_draining    = (r_state == StSend) || (r_state == StWaitAck);
    assign readyToSend   = (r_state == StSend);
    assign waitingForAck = (r_state == StWaitAck);
    assign occupancy     = r_occ;
    assign timeoutError  = r_timeout;
    assign dataOut       = w_draining ? r_data[r_rd_ptr][r_send_cnt] : '0;
    assign w_address     = w_draining ? {r_tag[r_rd_ptr], {OFFSET{1'b0}}} : '0;
    assign wordIndex     = w_draining ? r_send_cnt : '0;

    always_comb begin
        lookupHit = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == lookupAddress[ADDRESS_WIDTH-1:OFFSET])) lookupHit = 1'b1;
        end
    end

endmodule
